// File: rtl/demux_pkg.sv
// Shared widths, channel indices and frame constants
// for the registered 1-to-4 demultiplexer.
package demux_pkg;

    localparam int WIDTH = 4;
    localparam int N_CH  = 4;

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

    localparam logic [N_CH-1:0] FILLED_ALL = 4'b1111;

endpackage

// File: rtl/demux_1x4_4b_reg_if.sv
// Bus bundle between the word source / channel consumers
// and the demultiplexer.
import demux_pkg::*;

interface demux_1x4_4b_reg_if;

    logic [WIDTH-1:0] a;
    logic             S1;
    logic             S0;
    logic             auto_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] D0;
    logic [WIDTH-1:0] D1;
    logic [WIDTH-1:0] D2;
    logic [WIDTH-1:0] D3;
    logic [N_CH-1:0]  v;
    logic [N_CH-1:0]  ack;
    logic [1:0]       ch_atual;
    logic             frame_done;

    modport master (
        output a, S1, S0, auto_mode, in_valid, ack,
        input  in_ready, D0, D1, D2, D3, v, ch_atual, frame_done
    );

    modport slave (
        input  a, S1, S0, auto_mode, in_valid, ack,
        output in_ready, D0, D1, D2, D3, v, ch_atual, frame_done
    );

endinterface

// File: rtl/demux_1x4_4b_reg_decod_2x4.sv
// 2-to-4 one-hot decoder with enable; produces the
// per-channel write strobes of the demultiplexer.
import demux_pkg::*;

module decod_2x4 (
    input  logic            en,
    input  logic [1:0]      sel,
    output logic [N_CH-1:0] y
);

    always_comb begin
        y = '0;
        if (en) begin
            unique case (sel)
                CH0: y = 4'b0001;
                CH1: y = 4'b0010;
                CH2: y = 4'b0100;
                CH3: y = 4'b1000;
                default: y = '0;
            endcase
        end
    end

endmodule

// File: rtl/demux_1x4_4b_reg.sv
// Registered 1-to-4 demux with per-channel valid/ack,
// round-robin pointer and frame-complete pulse.
import demux_pkg::*;

module demux_1x4_4b_reg (
    input logic              clk,
    input logic              rst,
    demux_1x4_4b_reg_if.slave bus
);

    logic [N_CH-1:0][WIDTH-1:0] d_q, d_d;
    logic [N_CH-1:0]            v_q, v_d;
    logic [N_CH-1:0]            filled_q, filled_d;
    logic [1:0]                 ch_q, ch_d;
    logic                       frame_q, frame_d;

    logic [1:0]      k;
    logic            accept;
    logic [N_CH-1:0] we;
    logic [N_CH-1:0] filled_nxt;

    assign k = bus.auto_mode ? ch_q : {bus.S1, bus.S0};
    assign bus.in_ready = ~v_q[k] | bus.ack[k];
    assign accept = bus.in_valid & bus.in_ready;

    decod_2x4 u_dec (
        .en  (accept),
        .sel (k),
        .y   (we)
    );

    assign filled_nxt = filled_q | we;

    always_comb begin
        d_d      = d_q;
        v_d      = v_q & ~bus.ack;
        ch_d     = ch_q;
        filled_d = filled_nxt;
        frame_d  = 1'b0;
        // A write overrides a same-cycle ack on its own channel
        for (int i = 0; i < N_CH; i++) begin
            if (we[i]) begin
                d_d[i] = bus.a;
                v_d[i] = 1'b1;
            end
        end
        if (accept && bus.auto_mode)
            ch_d = ch_q + 2'd1;
        if (accept && filled_nxt == FILLED_ALL) begin
            filled_d = '0;
            frame_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q      <= '0;
            v_q      <= '0;
            filled_q <= '0;
            ch_q     <= CH0;
            frame_q  <= 1'b0;
        end else begin
            d_q      <= d_d;
            v_q      <= v_d;
            filled_q <= filled_d;
            ch_q     <= ch_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.D0         = d_q[0];
    assign bus.D1         = d_q[1];
    assign bus.D2         = d_q[2];
    assign bus.D3         = d_q[3];
    assign bus.v          = v_q;
    assign bus.ch_atual   = ch_q;
    assign bus.frame_done = frame_q;

endmodule
